ddr_init_sequencer: RTL and testbench

//  Power-up/re-init sequencer and refresh timebase for the DDR SDRAM front end.

---
 rtl/ddr_cmd_pkg.sv | 36 +++
 rtl/ddr_refresh_timer.sv | 36 +++
 rtl/ddr_init_sequencer.sv | 179 +++++++++++++++++
 tb/tb_ddr_init_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_cmd_pkg.sv
// SDRAM command codes and address constants shared by the init sequencer and state2,
// plus the init sequencer state type.
package ddr_cmd_pkg;

  // {RAS#, CAS#, WE#}
  localparam logic [2:0] CMD_MRST = 3'b000;
  localparam logic [2:0] CMD_ARSR = 3'b001;
  localparam logic [2:0] CMD_PRCH = 3'b010;
  localparam logic [2:0] CMD_ACTV = 3'b011;
  localparam logic [2:0] CMD_WRTE = 3'b100;
  localparam logic [2:0] CMD_READ = 3'b101;
  localparam logic [2:0] CMD_BTRM = 3'b110;
  localparam logic [2:0] CMD_NOOP = 3'b111;

  localparam logic [12:0] A10_PRECHARGE_ALL = 13'h0400;
  localparam logic [12:0] DLL_RESET_MASK    = 13'h0100;

  typedef enum logic [3:0] {
    S_PWRUP,
    S_CKEUP,
    S_PRE1,
    S_EMRS,
    S_MRSD,
    S_PRE2,
    S_REF,
    S_MRS,
    S_DLLW,
    S_RUN,
    S_QUIESCE
  } init_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr_refresh_timer.sv
// Refresh timebase: toggles REFRESH_STROBE every REF_INTVL enabled cycles.
// clear has priority so a re-init never produces a stray toggle.
module ddr_refresh_timer #(
  parameter int REF_INTVL = 780,
  parameter int CNT_W     = 10
) (
  input  logic CLK,
  input  logic RST,
  input  logic enable,
  input  logic clear,
  output logic REFRESH_STROBE
);

  logic [CNT_W-1:0] interval_cnt_reg;
  logic             strobe_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      interval_cnt_reg <= '0;
      strobe_reg       <= 1'b0;
    end else if (clear) begin
      interval_cnt_reg <= '0;
      strobe_reg       <= 1'b0;
    end else if (enable) begin
      if (interval_cnt_reg == CNT_W'(REF_INTVL - 1)) begin
        interval_cnt_reg <= '0;
        strobe_reg       <= ~strobe_reg;
      end else begin
        interval_cnt_reg <= interval_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign REFRESH_STROBE = strobe_reg;

endmodule

// File: rtl/ddr_init_sequencer.sv
// DDR SDRAM power-up / re-init sequencer: walks the JEDEC init command sequence,
// then hands the bus to state2 via INIT_DONE and runs the refresh timebase.
module ddr_init_sequencer
  import ddr_cmd_pkg::*;
#(
  parameter int          T_POWERUP  = 20000,
  parameter int          T_CKE      = 4,
  parameter int          T_RP       = 3,
  parameter int          T_MRD      = 2,
  parameter int          T_RFC      = 8,
  parameter int          T_DLL      = 200,
  parameter int          T_QUIESCE  = 8,
  parameter int          N_INIT_REF = 2,
  parameter int          REF_INTVL  = 780,
  parameter logic [12:0] MODE_REG   = 13'h0021,
  parameter logic [12:0] EXT_MODE   = 13'h0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REINIT,
  output logic        CKE,
  output logic [2:0]  COMMAND,
  output logic [12:0] ADDRESS,
  output logic [1:0]  BANK,
  output logic        INIT_DONE,
  output logic        REFRESH_STROBE
);

  localparam int CNT_W = $clog2(max2(T_POWERUP, REF_INTVL) + 1);
  localparam int DLL_W = $clog2(T_DLL + 1);

  init_state_t      state_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic [CNT_W-1:0] wait_limit;
  logic [DLL_W-1:0] dll_cnt_reg;
  logic [3:0]       ref_cnt_reg;
  logic             cke_reg;
  logic [2:0]       cmd_reg;
  logic [12:0]      addr_reg;
  logic [1:0]       bank_reg;
  logic             init_done_reg;

  logic wait_done;
  logic dll_done;
  logic in_run;
  logic reinit_accept;

  // Every state leaves on the edge T cycles after its entry edge; wait_cnt is 0 on entry.
  always_comb begin
    wait_limit = '0;
    case (state_reg)
      S_PWRUP:         wait_limit = CNT_W'(T_POWERUP - 1);
      S_CKEUP:         wait_limit = CNT_W'(T_CKE - 1);
      S_PRE1, S_PRE2:  wait_limit = CNT_W'(T_RP - 1);
      S_EMRS, S_MRSD,
      S_MRS:           wait_limit = CNT_W'(T_MRD - 1);
      S_REF:           wait_limit = CNT_W'(T_RFC - 1);
      S_QUIESCE:       wait_limit = CNT_W'(T_QUIESCE - 1);
      default:         wait_limit = '0;
    endcase
  end

  assign wait_done     = (wait_cnt_reg == wait_limit);
  // dll_cnt holds the number of cycles elapsed since the DLL-reset MRST, inclusive.
  assign dll_done      = (dll_cnt_reg >= DLL_W'(T_DLL));
  assign in_run        = (state_reg == S_RUN);
  assign reinit_accept = in_run && REINIT;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= S_PWRUP;
      wait_cnt_reg  <= '0;
      dll_cnt_reg   <= '0;
      ref_cnt_reg   <= '0;
      cke_reg       <= 1'b0;
      cmd_reg       <= CMD_NOOP;
      addr_reg      <= '0;
      bank_reg      <= '0;
      init_done_reg <= 1'b0;
    end else begin
      cmd_reg      <= CMD_NOOP;
      addr_reg     <= '0;
      bank_reg     <= '0;
      wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
      if (dll_cnt_reg != '0 && !dll_done)
        dll_cnt_reg <= dll_cnt_reg + DLL_W'(1);

      case (state_reg)
        S_PWRUP: if (wait_done) begin
          state_reg    <= S_CKEUP;
          cke_reg      <= 1'b1;
          wait_cnt_reg <= '0;
        end
        S_CKEUP, S_QUIESCE: if (wait_done) begin
          state_reg    <= S_PRE1;
          cmd_reg      <= CMD_PRCH;
          addr_reg     <= A10_PRECHARGE_ALL;
          wait_cnt_reg <= '0;
        end
        S_PRE1: if (wait_done) begin
          state_reg    <= S_EMRS;
          cmd_reg      <= CMD_MRST;
          bank_reg     <= 2'b01;
          addr_reg     <= EXT_MODE;
          wait_cnt_reg <= '0;
        end
        S_EMRS: if (wait_done) begin
          state_reg    <= S_MRSD;
          cmd_reg      <= CMD_MRST;
          addr_reg     <= MODE_REG | DLL_RESET_MASK;
          dll_cnt_reg  <= DLL_W'(1);
          wait_cnt_reg <= '0;
        end
        S_MRSD: if (wait_done) begin
          state_reg    <= S_PRE2;
          cmd_reg      <= CMD_PRCH;
          addr_reg     <= A10_PRECHARGE_ALL;
          wait_cnt_reg <= '0;
        end
        S_PRE2: if (wait_done) begin
          state_reg    <= S_REF;
          cmd_reg      <= CMD_ARSR;
          ref_cnt_reg  <= ref_cnt_reg + 4'd1;
          wait_cnt_reg <= '0;
        end
        S_REF: if (wait_done) begin
          wait_cnt_reg <= '0;
          if (ref_cnt_reg >= 4'(N_INIT_REF)) begin
            state_reg <= S_MRS;
            cmd_reg   <= CMD_MRST;
            addr_reg  <= MODE_REG;
          end else begin
            cmd_reg     <= CMD_ARSR;
            ref_cnt_reg <= ref_cnt_reg + 4'd1;
          end
        end
        S_MRS: if (wait_done) begin
          // Skip DLLW entirely when the DLL lock time has already elapsed.
          if (dll_done) begin
            state_reg     <= S_RUN;
            init_done_reg <= 1'b1;
          end else begin
            state_reg <= S_DLLW;
          end
        end
        S_DLLW: if (dll_done) begin
          state_reg     <= S_RUN;
          init_done_reg <= 1'b1;
        end
        S_RUN: if (REINIT) begin
          state_reg     <= S_QUIESCE;
          init_done_reg <= 1'b0;
          wait_cnt_reg  <= '0;
          ref_cnt_reg   <= '0;
          dll_cnt_reg   <= '0;
        end
        default: state_reg <= S_PWRUP;
      endcase
    end
  end

  ddr_refresh_timer #(
    .REF_INTVL (REF_INTVL),
    .CNT_W     (CNT_W)
  ) u_refresh_timer (
    .CLK            (CLK),
    .RST            (RST),
    .enable         (in_run),
    .clear          (reinit_accept),
    .REFRESH_STROBE (REFRESH_STROBE)
  );

  assign CKE       = cke_reg;
  assign COMMAND   = cmd_reg;
  assign ADDRESS   = addr_reg;
  assign BANK      = bank_reg;
  assign INIT_DONE = init_done_reg;

endmodule

// File: tb/tb_ddr_init_sequencer.sv
// Scoreboard bench for ddr_init_sequencer: a cycle-level reference model predicts every
// bus event (CKE edge, command, INIT_DONE edge, strobe edge); a monitor pops and compares.
module tb_ddr_init_sequencer;
  import ddr_cmd_pkg::*;

  localparam int TP   = 10;
  localparam int TC   = 2;
  localparam int TRP  = 3;
  localparam int TMRD = 2;
  localparam int TRFC = 5;
  localparam int TDLL = 20;
  localparam int TQ   = 4;
  localparam int NREF = 2;
  localparam int RI   = 16;
  localparam logic [12:0] MR  = 13'h0021;
  localparam logic [12:0] EMR = 13'h0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REINIT = 1'b0;
  logic        CKE, INIT_DONE, REFRESH_STROBE;
  logic [2:0]  COMMAND;
  logic [12:0] ADDRESS;
  logic [1:0]  BANK;

  logic        f_reinit = 1'b0;
  logic        f_cke, f_done, f_strobe;
  logic [2:0]  f_cmd;
  logic [12:0] f_addr;
  logic [1:0]  f_bank;

  ddr_init_sequencer #(
    .T_POWERUP(TP), .T_CKE(TC), .T_RP(TRP), .T_MRD(TMRD), .T_RFC(TRFC), .T_DLL(TDLL),
    .T_QUIESCE(TQ), .N_INIT_REF(NREF), .REF_INTVL(RI), .MODE_REG(MR), .EXT_MODE(EMR)
  ) u_dut (
    .CLK(CLK), .RST(RST), .REINIT(REINIT), .CKE(CKE), .COMMAND(COMMAND), .ADDRESS(ADDRESS),
    .BANK(BANK), .INIT_DONE(INIT_DONE), .REFRESH_STROBE(REFRESH_STROBE)
  );

  // Same timing but a DLL lock time that is always already satisfied.
  ddr_init_sequencer #(
    .T_POWERUP(TP), .T_CKE(TC), .T_RP(TRP), .T_MRD(TMRD), .T_RFC(TRFC), .T_DLL(1),
    .T_QUIESCE(TQ), .N_INIT_REF(NREF), .REF_INTVL(RI), .MODE_REG(MR), .EXT_MODE(EMR)
  ) u_fast (
    .CLK(CLK), .RST(RST), .REINIT(f_reinit), .CKE(f_cke), .COMMAND(f_cmd), .ADDRESS(f_addr),
    .BANK(f_bank), .INIT_DONE(f_done), .REFRESH_STROBE(f_strobe)
  );

  typedef struct {
    int          cyc;
    int          kind;  // 0 CKE, 1 command, 2 INIT_DONE, 3 REFRESH_STROBE
    logic [17:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc;

  always #5 CLK = ~CLK;

  always @(posedge CLK or posedge RST) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic push_ev(input bit en, input int c, input int k, input logic [17:0] d);
    ev_t e;
    if (en) begin
      e.cyc  = c;
      e.kind = k;
      e.data = d;
      exp_q.push_back(e);
    end
  endtask

  // Reference model of one init pass starting with the PRCH at cycle p.
  task automatic model_init(input int p, input int t_dll, input bit en,
                            output int mrs_c, output int done_c);
    int t;
    int mrsd;
    t = p;
    push_ev(en, t, 1, {2'b00, CMD_PRCH, 13'h0400});
    t += TRP;
    push_ev(en, t, 1, {2'b01, CMD_MRST, EMR});
    t += TMRD;
    mrsd = t;
    push_ev(en, t, 1, {2'b00, CMD_MRST, MR | 13'h0100});
    t += TMRD;
    push_ev(en, t, 1, {2'b00, CMD_PRCH, 13'h0400});
    t += TRP;
    for (int i = 0; i < NREF; i++) begin
      push_ev(en, t, 1, {2'b00, CMD_ARSR, 13'h0000});
      t += TRFC;
    end
    mrs_c = t;
    push_ev(en, t, 1, {2'b00, CMD_MRST, MR});
    done_c = (t + TMRD > mrsd + t_dll) ? t + TMRD : mrsd + t_dll;
    push_ev(en, done_c, 2, 18'd1);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cke"},    32'(CKE),            32'd0);
    check({tag, "_cmd"},    32'(COMMAND),        32'(CMD_NOOP));
    check({tag, "_addr"},   32'(ADDRESS),        32'd0);
    check({tag, "_bank"},   32'(BANK),           32'd0);
    check({tag, "_done"},   32'(INIT_DONE),      32'd0);
    check({tag, "_strobe"}, 32'(REFRESH_STROBE), 32'd0);
    check({tag, "_fast"},   {f_cke, f_done, f_strobe, f_cmd, f_bank, f_addr},
                            {3'b000, CMD_NOOP, 2'b00, 13'h0000});
  endtask

  task automatic see(input int k, input logic [17:0] d);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got cyc=%0d kind=%0d data=%h, required none", cyc, k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data !== d || e.cyc != cyc) begin
        bad++;
        $display("FAIL event: got cyc=%0d kind=%0d data=%h, required cyc=%0d kind=%0d data=%h",
                 cyc, k, d, e.cyc, e.kind, e.data);
      end else begin
        $display("ok cyc=%0d kind=%0d data=%h", cyc, k, d);
      end
    end
  endtask

  logic prev_cke, prev_done, prev_str;

  always @(negedge CLK) begin
    if (RST) begin
      prev_cke  <= 1'b0;
      prev_done <= 1'b0;
      prev_str  <= 1'b0;
    end else begin
      if (CKE !== prev_cke)             see(0, 18'(CKE));
      if (COMMAND !== CMD_NOOP)         see(1, {BANK, COMMAND, ADDRESS});
      if (INIT_DONE !== prev_done)      see(2, 18'(INIT_DONE));
      if (REFRESH_STROBE !== prev_str)  see(3, 18'(REFRESH_STROBE));
      prev_cke  <= CKE;
      prev_done <= INIT_DONE;
      prev_str  <= REFRESH_STROBE;
    end
  end

  int   fast_done_cyc;
  int   fast_mrs_cyc;
  logic fast_done_prev;

  always @(negedge CLK) begin
    if (RST) begin
      fast_done_cyc  <= -1;
      fast_mrs_cyc   <= -1;
      fast_done_prev <= 1'b0;
    end else begin
      if (f_cmd == CMD_MRST)         fast_mrs_cyc  <= cyc;
      if (f_done && !fast_done_prev) fast_done_cyc <= cyc;
      fast_done_prev <= f_done;
    end
  end

  task automatic drive_pulse(input int at);
    if (cyc > at - 1) begin
      total++;
      bad++;
      $display("FAIL pulse_schedule: now=%0d, required <= %0d", cyc, at - 1);
    end
    while (cyc < at - 1) @(negedge CLK);
    REINIT = 1'b1;
    @(negedge CLK);
    REINIT = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge CLK);
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, dn, mrs_c, fm, fd, r, ig, p, m, s;

    RST    = 1'b1;
    REINIT = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset("por");

    // Start a sequence, then hit it with an asynchronous reset while EMRS is on the bus.
    push_ev(1, TP, 0, 18'd1);
    model_init(TP + TC, TDLL, 1, mrs_c, d);
    RST = 1'b0;
    while (cyc < TP + TC + TRP) @(negedge CLK);
    #2 RST = 1'b1;
    #1 check_reset("async");
    repeat (3) @(negedge CLK);
    check_reset("held");
    exp_q.delete();

    push_ev(1, TP, 0, 18'd1);
    model_init(TP + TC, TDLL, 1, mrs_c, d);
    $display("init from reset: INIT_DONE expected at cyc=%0d", d);
    RST = 1'b0;

    model_init(TP + TC, 1, 0, fm, fd);
    while (cyc < fd + 2) @(negedge CLK);
    check("fast_done_cyc", 32'(fast_done_cyc), 32'(fd));
    check("fast_mrs_cyc", 32'(fast_mrs_cyc), 32'(fm));
    check("fast_mrs_to_done", 32'(fast_done_cyc - fast_mrs_cyc), 32'(TMRD));

    for (int it = 0; it < 6; it++) begin
      if (it == 0) begin
        r = d + RI;
      end else if (it == 1) begin
        r = d + RI + int'($urandom_range(1, RI - 1));
      end else begin
        m = int'($urandom_range(0, 3));
        if (m > 0 && $urandom_range(0, 1) == 1) r = d + RI * m;
        else                                    r = d + RI * m + int'($urandom_range(1, RI - 1));
      end

      s = 0;
      for (int j = 1; d + RI * j < r; j++) begin
        s ^= 1;
        push_ev(1, d + RI * j, 3, 18'(s));
      end
      push_ev(1, r, 2, 18'd0);
      if (s != 0) push_ev(1, r, 3, 18'd0);
      p = r + TQ;
      model_init(p, TDLL, 1, mrs_c, dn);

      if (it == 0)      ig = dn;
      else if (it == 1) ig = p + 2 * TRP + 2 * TMRD + 1;
      else              ig = r + 1 + int'($urandom_range(0, dn - r - 1));

      $display("reinit at cyc=%0d strobe=%0d, ignored pulse at cyc=%0d, next INIT_DONE at cyc=%0d",
               r, s, ig, dn);
      drive_pulse(r);
      drive_pulse(ig);
      d = dn;
    end

    push_ev(1, d + RI,     3, 18'd1);
    push_ev(1, d + RI * 2, 3, 18'd0);
    push_ev(1, d + RI * 3, 3, 18'd1);
    while (cyc < d + RI * 3 + 8) @(negedge CLK);
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
